// File: rtl/delay_pipe_pkg.sv
// delay_pipe_pkg: shared sizing constants and token type for the delay pipeline
package delay_pipe_pkg;

    localparam int DELAY_WIDTH = 5;
    localparam int DELAY_DEPTH = 3;

    typedef struct packed {
        logic [DELAY_WIDTH-1:0] data;
        logic                   valid;
    } delay_token_t;

endpackage

// File: rtl/delay_lane.sv
// delay_lane: one stallable, bubble-collapsing ready/valid delay lane
module delay_lane
    import delay_pipe_pkg::*;
#(
    parameter int WIDTH = DELAY_WIDTH,
    parameter int DEPTH = DELAY_DEPTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [WIDTH-1:0]             i_in_data,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    output logic [WIDTH-1:0]             o_out_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_occ
);

    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [OW-1:0]    r_occ;
    logic [DEPTH-1:0] w_go;
    logic [DEPTH-1:0] w_valid_nxt;
    logic [OW-1:0]    w_cnt;

    genvar k;

    // A stage may advance unless it and every stage after it are full while the output stalls;
    // written as a reduction over the registers so the chain has no combinational feedback
    generate
        for (k = 0; k < DEPTH; k++) begin : g_go
            assign w_go[k] = i_out_ready | ~(&r_valid[DEPTH-1:k]);
        end
    endgenerate

    // Next valid bits: load from upstream when advancing, otherwise hold
    assign w_valid_nxt[0] = w_go[0] ? i_in_valid : r_valid[0];
    generate
        for (k = 1; k < DEPTH; k++) begin : g_vn
            assign w_valid_nxt[k] = w_go[k] ? r_valid[k-1] : r_valid[k];
        end
    endgenerate

    // Population count of the next valid bits so OCC matches the stages after the edge
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < DEPTH; i++) w_cnt = w_cnt + OW'(w_valid_nxt[i]);
    end

    // Stage registers and occupancy; reset clears data too so the output reads 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_cnt;
            if (w_go[0]) r_data[0] <= i_in_data;
            for (int i = 1; i < DEPTH; i++) if (w_go[i]) r_data[i] <= r_data[i-1];
        end
    end

    assign o_in_ready  = w_go[0] & ~i_rst;
    assign o_out_valid = r_valid[DEPTH-1];
    assign o_out_data  = r_data[DEPTH-1];
    assign o_occ       = r_occ;

endmodule

// File: rtl/delay_pipe.sv
// delay_pipe: two independent delay lanes, indices preserved
module delay_pipe
    import delay_pipe_pkg::*;
#(
    parameter int WIDTH = DELAY_WIDTH,
    parameter int DEPTH = DELAY_DEPTH
) (
    input  logic                       CLK,
    input  logic                       ASYNCRESET,
    input  logic [WIDTH-1:0]           INPUT_0_data,
    input  logic                       INPUT_0_valid,
    output logic                       INPUT_0_ready,
    input  logic [WIDTH-1:0]           INPUT_1_data,
    input  logic                       INPUT_1_valid,
    output logic                       INPUT_1_ready,
    output logic [WIDTH-1:0]           OUTPUT_0_data,
    output logic                       OUTPUT_0_valid,
    input  logic                       OUTPUT_0_ready,
    output logic [WIDTH-1:0]           OUTPUT_1_data,
    output logic                       OUTPUT_1_valid,
    input  logic                       OUTPUT_1_ready,
    output logic [$clog2(DEPTH+1)-1:0] OCC_0,
    output logic [$clog2(DEPTH+1)-1:0] OCC_1
);

    delay_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) lane0 (
        .i_clk       (CLK),
        .i_rst       (ASYNCRESET),
        .i_in_data   (INPUT_0_data),
        .i_in_valid  (INPUT_0_valid),
        .o_in_ready  (INPUT_0_ready),
        .o_out_data  (OUTPUT_0_data),
        .o_out_valid (OUTPUT_0_valid),
        .i_out_ready (OUTPUT_0_ready),
        .o_occ       (OCC_0)
    );

    delay_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) lane1 (
        .i_clk       (CLK),
        .i_rst       (ASYNCRESET),
        .i_in_data   (INPUT_1_data),
        .i_in_valid  (INPUT_1_valid),
        .o_in_ready  (INPUT_1_ready),
        .o_out_data  (OUTPUT_1_data),
        .o_out_valid (OUTPUT_1_valid),
        .i_out_ready (OUTPUT_1_ready),
        .o_occ       (OCC_1)
    );

endmodule

// File: tb/tb_delay_pipe.sv
// tb_delay_pipe: randomized and directed checks of delay_pipe against a token-queue model
module tb_delay_pipe;

    localparam int W = 5;
    localparam int D = 3;

    typedef struct {
        int d;
        int t;
    } tok_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in0_d = '0, in1_d = '0;
    logic         in0_v = 1'b0, in1_v = 1'b0;
    logic         out0_r = 1'b0, out1_r = 1'b0;
    logic [W-1:0] out0_d, out1_d;
    logic         in0_r, in1_r, out0_v, out1_v;
    logic [1:0]   occ0, occ1;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic acc0, acc1;
    tok_t q0[$];
    tok_t q1[$];

    always #5 clk = ~clk;

    delay_pipe dut (
        .CLK            (clk),
        .ASYNCRESET     (rst),
        .INPUT_0_data   (in0_d),
        .INPUT_0_valid  (in0_v),
        .INPUT_0_ready  (in0_r),
        .INPUT_1_data   (in1_d),
        .INPUT_1_valid  (in1_v),
        .INPUT_1_ready  (in1_r),
        .OUTPUT_0_data  (out0_d),
        .OUTPUT_0_valid (out0_v),
        .OUTPUT_0_ready (out0_r),
        .OUTPUT_1_data  (out1_d),
        .OUTPUT_1_valid (out1_v),
        .OUTPUT_1_ready (out1_r),
        .OCC_0          (occ0),
        .OCC_1          (occ1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive, check against the queue model, advance the model, cross the edge.
    // A token is visible at the output once it is the oldest in flight and DEPTH cycles have
    // passed since it was accepted; the lane is full exactly when DEPTH tokens are in flight.
    task automatic cycle(input logic v0, input logic [W-1:0] d0, input logic r0,
                         input logic v1, input logic [W-1:0] d1, input logic r1);
        logic e_r0, e_v0, e_r1, e_v1;
        in0_v = v0; in0_d = d0; out0_r = r0;
        in1_v = v1; in1_d = d1; out1_r = r1;
        #3;
        e_r0 = !rst && (q0.size() < D || r0);
        e_v0 = !rst && q0.size() > 0 && cyc >= q0[0].t + D;
        e_r1 = !rst && (q1.size() < D || r1);
        e_v1 = !rst && q1.size() > 0 && cyc >= q1[0].t + D;
        chk("in0_ready", 32'(in0_r), 32'(e_r0));
        chk("out0_valid", 32'(out0_v), 32'(e_v0));
        if (e_v0) chk("out0_data", 32'(out0_d), q0[0].d);
        else if (rst) chk("out0_data_rst", 32'(out0_d), 0);
        chk("occ0", 32'(occ0), q0.size());
        chk("in1_ready", 32'(in1_r), 32'(e_r1));
        chk("out1_valid", 32'(out1_v), 32'(e_v1));
        if (e_v1) chk("out1_data", 32'(out1_d), q1[0].d);
        else if (rst) chk("out1_data_rst", 32'(out1_d), 0);
        chk("occ1", 32'(occ1), q1.size());
        acc0 = v0 && e_r0;
        acc1 = v1 && e_r1;
        if (e_v0 && r0) void'(q0.pop_front());
        if (e_v1 && r1) void'(q1.pop_front());
        if (acc0) q0.push_back('{int'(d0), cyc});
        if (acc1) q1.push_back('{int'(d1), cyc});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Half-cycle reset pulse between edges; everything in flight is discarded
    task automatic pulse_reset();
        in0_v = 1'b0;
        in1_v = 1'b0;
        #2 rst = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        chk("rst_out0_valid", 32'(out0_v), 0);
        chk("rst_out1_valid", 32'(out1_v), 0);
        chk("rst_out0_data", 32'(out0_d), 0);
        chk("rst_out1_data", 32'(out1_d), 0);
        chk("rst_occ0", 32'(occ0), 0);
        chk("rst_occ1", 32'(occ1), 0);
        chk("rst_in0_ready", 32'(in0_r), 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int k;
        repeat (2) cycle(1'b1, 5'h1f, 1'b1, 1'b1, 5'h0a, 1'b1);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        chk("ready_after_reset", 32'(in0_r), 1);

        cycle(1'b1, 5'h15, 1'b1, 1'b0, '0, 1'b1);
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        for (int i = 0; i < 32; i++) cycle(1'b0, '0, 1'b1, 1'b1, W'(i), 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        k = 1;
        for (int n = 0; n < 6; n++) begin
            cycle(1'b1, W'(k), 1'b0, 1'b0, '0, 1'b1);
            if (acc0) k++;
        end
        chk("bp_accepted", k - 1, 3);
        for (int n = 0; n < 8; n++) begin
            cycle(k <= 4, W'(k), 1'b1, 1'b0, '0, 1'b1);
            if (acc0) k++;
        end
        chk("bp_fourth_taken", k, 5);

        for (int n = 0; n < 20; n++) cycle(1'b1, W'($urandom), 1'b0, 1'b1, W'(n + 7), 1'b1);
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        repeat (3) cycle(1'b1, W'($urandom), 1'b0, 1'b1, W'($urandom), 1'b0);
        pulse_reset();
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        for (int n = 0; n < 800; n++) begin
            if ($urandom % 150 == 0) pulse_reset();
            else cycle(($urandom % 3) != 0, W'($urandom), ($urandom % 4) != 0,
                       ($urandom % 2) != 0, W'($urandom), ($urandom % 3) == 0);
        end
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
